bsg_axis_packetizer: RTL and testbench

Upstream feeder for the AXI-stream FIFO on the Zynq shell path. It takes a plain valid/ready word stream from the BlackParrot side and frames it into AXI-stream packets. It asserts tlast on the beat that completes a programmable packet length, on an idle timeout, or on an explicit flush. A one-beat hold register lets the block assign tlast to a beat that has already been accepted.

---
 rtl/bsg_axis_packetizer_pkg.sv | 9 +
 rtl/bsg_axis_packetizer_hold.sv | 77 +++++++
 rtl/bsg_axis_packetizer.sv | 111 +++++++++++
 tb/tb_bsg_axis_packetizer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_axis_packetizer_pkg.sv
// Shared helpers for the AXI-stream packetizer.
package bsg_axis_packetizer_pkg;

  // True when a beat at packet index idx is the final beat of a len-beat packet.
  function automatic logic is_term_idx(input int unsigned idx, input int unsigned len);
    return (idx + 1) == len;
  endfunction

endpackage

// File: rtl/bsg_axis_packetizer_hold.sv
// One-beat hold register in front of the AXIS output register. A beat waits
// here until it is known whether it ends its packet (terminal index, the
// next accept, an idle timeout, or a flush). The idle counter lives here too.
module bsg_axis_packetizer_hold #(
  parameter int width_p   = 32,
  parameter int timeout_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               term_i,
  input  logic               o_free_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic               accept_o,
  output logic               move_o,
  output logic               last_o,
  output logic [width_p-1:0] data_o,
  output logic               term_o
);

  localparam int idle_w_lp = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
  localparam logic [idle_w_lp-1:0] timeout_lp = idle_w_lp'(timeout_p);

  logic               h_v_q, h_v_d;
  logic [width_p-1:0] h_data_q, h_data_d;
  logic               h_term_q, h_term_d;
  logic [idle_w_lp-1:0] idle_cnt_q, idle_cnt_d;
  logic               timeout;

  // H can take a beat when empty or when its current beat can leave this cycle.
  assign ready_o  = ~h_v_q | o_free_i;
  assign accept_o = v_i & ready_o;
  assign timeout  = (timeout_p != 0) && (idle_cnt_q == timeout_lp);
  assign move_o   = h_v_q & o_free_i & (h_term_q | accept_o | timeout | flush_i);
  // A following accept means the held beat was not the last one.
  assign last_o   = h_term_q | (~accept_o & (timeout | flush_i));
  assign data_o   = h_data_q;
  assign term_o   = h_term_q;

  // Next-state for H and the saturating idle counter.
  always_comb begin
    h_v_d      = h_v_q;
    h_data_d   = h_data_q;
    h_term_d   = h_term_q;
    idle_cnt_d = idle_cnt_q;
    if (accept_o) begin
      h_v_d    = 1'b1;
      h_data_d = data_i;
      h_term_d = term_i;
    end else if (move_o) begin
      h_v_d = 1'b0;
    end
    if (accept_o || !h_v_q) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != timeout_lp) begin
      idle_cnt_d = idle_cnt_q + idle_w_lp'(1);
    end
  end

  // H state registers; reset discards any held beat.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      h_v_q      <= 1'b0;
      h_data_q   <= '0;
      h_term_q   <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      h_v_q      <= h_v_d;
      h_data_q   <= h_data_d;
      h_term_q   <= h_term_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: rtl/bsg_axis_packetizer.sv
// Frames a valid/ready word stream into AXI-stream packets. tlast marks the
// beat that completes the programmed length, or the beat left pending when
// the stream goes idle for timeout_p cycles or flush_i is raised.
module bsg_axis_packetizer
  import bsg_axis_packetizer_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int max_pkt_beats_p      = 256,
  parameter int timeout_p            = 64,
  localparam int lg_max_p            = $clog2(max_pkt_beats_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [lg_max_p-1:0]               pkt_len_i,
  input  logic                              flush_i,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   data_i,
  input  logic                              v_i,
  output logic                              ready_o,
  output logic                              m_axis_tvalid_o,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   m_axis_tdata_o,
  output logic [C_S00_AXI_DATA_WIDTH/8-1:0] m_axis_tkeep_o,
  output logic                              m_axis_tlast_o,
  input  logic                              m_axis_tready_i
);

  localparam logic [lg_max_p-1:0] max_len_lp = lg_max_p'(max_pkt_beats_p);

  logic [lg_max_p-1:0] next_idx_q, next_idx_d;
  logic [lg_max_p-1:0] len_r_q, len_r_d;
  logic [lg_max_p-1:0] len_new, len_eff;
  logic                term_new;
  logic                o_v_q, o_v_d;
  logic [C_S00_AXI_DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                o_last_q, o_last_d;
  logic                o_free, accept, move, move_last, h_term;
  logic [C_S00_AXI_DATA_WIDTH-1:0] h_data;

  // A new packet samples pkt_len_i; mid-packet beats use the latched length.
  assign len_new  = (pkt_len_i == '0) ? max_len_lp : pkt_len_i;
  assign len_eff  = (next_idx_q == '0) ? len_new : len_r_q;
  assign term_new = is_term_idx(32'(next_idx_q), 32'(len_eff));
  assign o_free   = ~o_v_q | m_axis_tready_i;

  bsg_axis_packetizer_hold #(
    .width_p  (C_S00_AXI_DATA_WIDTH),
    .timeout_p(timeout_p)
  ) hold (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .term_i  (term_new),
    .o_free_i(o_free),
    .flush_i (flush_i),
    .ready_o (ready_o),
    .accept_o(accept),
    .move_o  (move),
    .last_o  (move_last),
    .data_o  (h_data),
    .term_o  (h_term)
  );

  // Packet index tracking; a timeout/flush close restarts indexing at 0.
  always_comb begin
    next_idx_d = next_idx_q;
    len_r_d    = len_r_q;
    if (accept) begin
      if (next_idx_q == '0) len_r_d = len_new;
      next_idx_d = term_new ? '0 : next_idx_q + lg_max_p'(1);
    end else if (move && move_last && !h_term) begin
      next_idx_d = '0;
    end
  end

  // Output register: refilled from H, drained by the AXIS handshake.
  always_comb begin
    o_v_d    = o_v_q;
    o_data_d = o_data_q;
    o_last_d = o_last_q;
    if (move) begin
      o_v_d    = 1'b1;
      o_data_d = h_data;
      o_last_d = move_last;
    end else if (m_axis_tready_i) begin
      o_v_d = 1'b0;
    end
  end

  // Framing and output state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      next_idx_q <= '0;
      len_r_q    <= max_len_lp;
      o_v_q      <= 1'b0;
      o_data_q   <= '0;
      o_last_q   <= 1'b0;
    end else begin
      next_idx_q <= next_idx_d;
      len_r_q    <= len_r_d;
      o_v_q      <= o_v_d;
      o_data_q   <= o_data_d;
      o_last_q   <= o_last_d;
    end
  end

  assign m_axis_tvalid_o = o_v_q;
  assign m_axis_tdata_o  = o_data_q;
  assign m_axis_tlast_o  = o_last_q;
  assign m_axis_tkeep_o  = '1;

endmodule

// File: tb/tb_bsg_axis_packetizer.sv
// Bench for bsg_axis_packetizer: directed framing scenarios plus a randomized
// backpressure run, all scored against a packet-level reference model.
module tb_bsg_axis_packetizer;

  localparam int DW   = 32;
  localparam int MAXB = 256;
  localparam int TO   = 64;
  localparam int LGM  = $clog2(MAXB + 1);

  logic            clk = 1'b0;
  logic            reset_i = 1'b1;
  logic [LGM-1:0]  pkt_len_i = LGM'(4);
  logic            flush_i = 1'b0;
  logic [DW-1:0]   data_i = '0;
  logic            v_i = 1'b0;
  logic            ready_o;
  logic            m_axis_tvalid_o;
  logic [DW-1:0]   m_axis_tdata_o;
  logic [DW/8-1:0] m_axis_tkeep_o;
  logic            m_axis_tlast_o;
  logic            m_axis_tready_i = 1'b1;

  bsg_axis_packetizer dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .pkt_len_i      (pkt_len_i),
    .flush_i        (flush_i),
    .data_i         (data_i),
    .v_i            (v_i),
    .ready_o        (ready_o),
    .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tdata_o (m_axis_tdata_o),
    .m_axis_tkeep_o (m_axis_tkeep_o),
    .m_axis_tlast_o (m_axis_tlast_o),
    .m_axis_tready_i(m_axis_tready_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected beats in accept order with their tlast flag.
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          idx_m = 0;
  int          len_m = MAXB;
  logic        pend = 1'b0;
  int          idle_m = 0;
  logic        m_acc;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;
  int          pushes = 0;
  int          pops = 0;
  int          lat_by_data [logic [31:0]];
  logic        last_by_data [logic [31:0]];

  // Everything sampled at the negedge describes the upcoming posedge.
  always @(negedge clk) begin
    if (reset_i) begin
      exp_q.delete();
      idx_m = 0; len_m = MAXB; pend = 1'b0; idle_m = 0; stall_prev = 1'b0;
    end else begin
      m_acc = v_i && ready_o;
      if (stall_prev) begin
        chk("stall_tvalid", 32'(m_axis_tvalid_o), 1);
        chk("stall_tdata", m_axis_tdata_o, prev_d);
        chk("stall_tlast", 32'(m_axis_tlast_o), 32'(prev_l));
      end
      stall_prev = m_axis_tvalid_o && !m_axis_tready_i;
      prev_d = m_axis_tdata_o;
      prev_l = m_axis_tlast_o;
      // A partial packet left pending closes on flush or after TO idle cycles.
      if (pend && !m_acc && m_axis_tready_i && (flush_i || idle_m == TO)) begin
        e = exp_q[exp_q.size()-1];
        e.last = 1'b1;
        exp_q[exp_q.size()-1] = e;
        pend = 1'b0;
        idx_m = 0;
      end else if (pend && !m_acc && idle_m < TO) begin
        idle_m++;
      end
      if (m_axis_tvalid_o && m_axis_tready_i) begin
        pops++;
        chk("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_tdata", m_axis_tdata_o, e.data);
          chk("out_tlast", 32'(m_axis_tlast_o), 32'(e.last));
          chk("out_tkeep", 32'(m_axis_tkeep_o), 32'hF);
          lat_by_data[e.data] = cyc - int'(e.cyc);
          last_by_data[e.data] = m_axis_tlast_o;
        end
      end
      if (m_acc) begin
        pushes++;
        if (idx_m == 0) len_m = (pkt_len_i == '0) ? MAXB : int'(pkt_len_i);
        e.data = data_i;
        e.last = (idx_m == len_m - 1);
        e.cyc  = 32'(cyc);
        exp_q.push_back(e);
        idx_m  = e.last ? 0 : idx_m + 1;
        pend   = !e.last;
        idle_m = 0;
      end
    end
  end

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) align();
  endtask

  // Offer one word; returns one cycle after acceptance, still aligned.
  task automatic send(input logic [31:0] d);
    int   g = 0;
    logic took = 1'b0;
    v_i = 1'b1;
    data_i = d;
    while (!took && g < 200) begin
      @(negedge clk);
      took = ready_o;
      g++;
      align();
    end
    if (!took) chk("send_accepted", 0, 1);
    v_i = 1'b0;
  endtask

  // Waits (bounded) for a beat to leave on AXIS, then checks tlast and latency.
  task automatic check_beat(input string tag, input logic [31:0] key,
                            input logic exp_last, input int exp_lat);
    int g = 0;
    while (!lat_by_data.exists(key) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_seen"}, 32'(lat_by_data.exists(key)), 1);
    if (lat_by_data.exists(key)) begin
      chk({tag, "_tlast"}, 32'(last_by_data[key]), 32'(exp_last));
      if (exp_lat >= 0) chk({tag, "_lat"}, 32'(lat_by_data[key]), 32'(exp_lat));
    end
    align();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n;
    int   vrun;
    int   trun;
    logic acc;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid_o), 0);
    chk("rst_tlast", 32'(m_axis_tlast_o), 0);
    chk("rst_tdata", m_axis_tdata_o, 0);
    chk("rst_tkeep", 32'(m_axis_tkeep_o), 32'hF);
    chk("rst_ready", 32'(ready_o), 1);
    align();
    reset_i = 1'b0;
    idle(2);

    // Two back-to-back 4-beat packets.
    lat_by_data.delete(); last_by_data.delete();
    pkt_len_i = LGM'(4);
    for (int i = 0; i < 8; i++) send(32'hA000_0000 + 32'(i));
    idle(5);
    for (int i = 0; i < 8; i++)
      check_beat("len4", 32'hA000_0000 + 32'(i), (i == 3 || i == 7), (i == 7) ? 2 : -1);

    // Max-length packet followed by a partial packet closed by timeout.
    // The timeout move lands 65 edges after accept, the handshake one edge later.
    lat_by_data.delete(); last_by_data.delete();
    pkt_len_i = '0;
    for (int i = 0; i < 300; i++) send(32'hB000_0000 + 32'(i));
    idle(80);
    check_beat("max_254", 32'hB000_0000 + 32'd254, 1'b0, -1);
    check_beat("max_255", 32'hB000_0000 + 32'd255, 1'b1, 2);
    check_beat("max_298", 32'hB000_0000 + 32'd298, 1'b0, -1);
    check_beat("max_299", 32'hB000_0000 + 32'd299, 1'b1, 66);

    // Short packet closed by timeout; the next beat opens a fresh packet.
    lat_by_data.delete(); last_by_data.delete();
    pkt_len_i = LGM'(8);
    for (int i = 0; i < 3; i++) send(32'hC000_0000 + 32'(i));
    idle(80);
    check_beat("to_c1", 32'hC000_0001, 1'b0, -1);
    check_beat("to_c2", 32'hC000_0002, 1'b1, 66);
    for (int i = 3; i < 11; i++) send(32'hC000_0000 + 32'(i));
    idle(5);
    check_beat("to_c9", 32'hC000_0009, 1'b0, -1);
    check_beat("to_c10", 32'hC000_000A, 1'b1, 2);

    // Flush concurrent with an accept does not close the packet.
    lat_by_data.delete(); last_by_data.delete();
    for (int i = 0; i < 5; i++) send(32'hD000_0000 + 32'(i));
    flush_i = 1'b1;
    send(32'hD000_0005);
    flush_i = 1'b0;
    idle(80);
    check_beat("flacc_d4", 32'hD000_0004, 1'b0, -1);
    check_beat("flacc_d5", 32'hD000_0005, 1'b1, 66);

    // Flush alone closes the pending beat; flush on an empty H does nothing.
    lat_by_data.delete(); last_by_data.delete();
    for (int i = 0; i < 5; i++) send(32'hE000_0000 + 32'(i));
    idle(1);
    flush_i = 1'b1;
    align();
    flush_i = 1'b0;
    idle(4);
    check_beat("fl_e3", 32'hE000_0003, 1'b0, -1);
    check_beat("fl_e4", 32'hE000_0004, 1'b1, -1);
    flush_i = 1'b1;
    align();
    flush_i = 1'b0;
    @(negedge clk);
    chk("fl_empty_tvalid", 32'(m_axis_tvalid_o), 0);
    align();
    pkt_len_i = LGM'(2);
    send(32'hE000_0005);
    send(32'hE000_0006);
    idle(4);
    check_beat("fl_e5", 32'hE000_0005, 1'b0, -1);
    check_beat("fl_e6", 32'hE000_0006, 1'b1, 2);

    // Random valid and backpressure, 3-beat packets.
    pkt_len_i = LGM'(3);
    n = 0; vrun = 0; trun = 0;
    while (n < 1000 && cyc < 30000) begin
      @(negedge clk);
      acc = v_i && ready_o;
      align();
      if (acc) n++;
      if (!(v_i && !acc)) begin
        v_i = ($urandom_range(1, 0) == 1) || (vrun >= 20);
        data_i = $urandom;
        vrun = v_i ? 0 : vrun + 1;
      end
      m_axis_tready_i = ($urandom_range(1, 0) == 1) || (trun >= 20);
      trun = m_axis_tready_i ? 0 : trun + 1;
    end
    v_i = 1'b0;
    m_axis_tready_i = 1'b1;
    chk("rand_beats", 32'(n), 1000);
    idle(100);
    chk("rand_drained", 32'(exp_q.size()), 0);
    chk("rand_pop_push", 32'(pops), 32'(pushes));

    // Reset with both O and H occupied.
    lat_by_data.delete(); last_by_data.delete();
    pkt_len_i = LGM'(4);
    m_axis_tready_i = 1'b0;
    send(32'hF000_0000);
    send(32'hF000_0001);
    @(negedge clk);
    chk("bp_ready_low", 32'(ready_o), 0);
    chk("bp_tvalid", 32'(m_axis_tvalid_o), 1);
    chk("bp_tdata", m_axis_tdata_o, 32'hF000_0000);
    align();
    reset_i = 1'b1;
    #1;
    chk("mid_rst_tvalid", 32'(m_axis_tvalid_o), 0);
    chk("mid_rst_ready", 32'(ready_o), 1);
    idle(2);
    reset_i = 1'b0;
    m_axis_tready_i = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send(32'h9000_0000 + 32'(i));
    idle(5);
    check_beat("post_rst_g2", 32'h9000_0002, 1'b0, -1);
    check_beat("post_rst_g3", 32'h9000_0003, 1'b1, 2);
    chk("post_rst_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
